data_memory_core: RTL and testbench

- Single-port, word-addressed data memory for the processor datapath (load/store stage).
- One shared read/write address.
- Synchronous write on the clock edge; asynchronous (combinational) read.
- Width parameter sets both data width and address width; depth is 2**N words.

---
 rtl/data_memory_core.sv | 60 ++++++
 tb/tb_data_memory_core.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_core.sv
// Single-port word-addressed data memory for the load/store stage.
// Latency: write commits on rising clk; read is combinational (zero cycles).
// Backpressure: none; no handshake or stall, at most one write per cycle.
//
// Ports:
//   clk                 - system clock; writes happen on its rising edge
//   reset               - asynchronous active-high; clears every word to 0
//   memory_write_enable - 1 = store data_in at address_rw on the next edge
//   address_rw          - shared read/write word address (N bits)
//   data_in             - write data (N bits)
//   data_out            - read data at address_rw (N bits)
//
// Optional build macro: DATA_MEMORY_WRITE_FORWARD_EN
//   When defined, data_out shows data_in while a write is pending
//   (memory_write_enable=1, reset=0). Storage timing is unchanged.
module data_memory_core #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memory_write_enable,
  input  logic [N-1:0] address_rw,
  input  logic [N-1:0] data_in,
  output logic [N-1:0] data_out
);

  localparam int DEPTH = 1 << N;

  // Every N-bit address maps to exactly one of the DEPTH words.
  logic [N-1:0] mem [DEPTH];

  // Reset is in the sensitivity list so clearing does not wait for clk,
  // and a clk edge seen while reset is high takes the clear branch, so a
  // write coinciding with reset is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (memory_write_enable) begin
      mem[address_rw] <= data_in;
    end
  end

`ifdef DATA_MEMORY_WRITE_FORWARD_EN
  // Write-through: the pending write value is visible before the edge.
  always_comb begin
    data_out = mem[address_rw];
    if (memory_write_enable && !reset) begin
      data_out = data_in;
    end
  end
`else
  // Plain asynchronous read: old contents until the edge, new after it.
  always_comb begin
    data_out = mem[address_rw];
  end
`endif

endmodule

// File: tb/tb_data_memory_core.sv
module tb_data_memory_core;

  localparam int N = 2;
  localparam int DEPTH = 1 << N;

  logic         clk;
  logic         reset;
  logic         memory_write_enable;
  logic [N-1:0] address_rw;
  logic [N-1:0] data_in;
  logic [N-1:0] data_out;

  int checks = 0;
  int errors = 0;

  // Reference contents and scoreboard of expected read values.
  logic [N-1:0] model [DEPTH];
  logic [N-1:0] exp_q [$];
  logic [N-1:0] exp_v;

  data_memory_core #(.N(N)) dut (
    .clk                 (clk),
    .reset               (reset),
    .memory_write_enable (memory_write_enable),
    .address_rw          (address_rw),
    .data_in             (data_in),
    .data_out            (data_out)
  );

  // 100-unit clock period; rising edges at 50, 150, 250, ...
  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial begin
    #90000;
    $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
    $fatal(1);
  end

  task automatic test_reset();
    reset = 1'b0;
    memory_write_enable = 1'b0;
    address_rw = '0;
    data_in = '0;
    #5;
    reset = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      model[a] = '0;
    end
    for (int a = 0; a < DEPTH; a++) begin
      address_rw = N'(a);
      exp_q.push_back(model[a]);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (data_out !== exp_v) begin
        errors++;
        $display("FAIL reset_state addr=%0d got=%b exp=%b", a, data_out, exp_v);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_write_sweep();
    logic [N-1:0] wd [DEPTH];
    wd[0] = 2'b11; wd[1] = 2'b10; wd[2] = 2'b01; wd[3] = 2'b00;
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      memory_write_enable = 1'b1;
      address_rw = N'(a);
      data_in = wd[a];
      model[a] = wd[a];
      exp_q.push_back(wd[a]);
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (data_out !== exp_v) begin
        errors++;
        $display("FAIL write_sweep addr=%0d got=%b exp=%b", a, data_out, exp_v);
      end
    end
    @(negedge clk);
    memory_write_enable = 1'b0;
  endtask

  task automatic test_read_back();
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      memory_write_enable = 1'b0;
      address_rw = N'(a);
      data_in = ~model[a];
      exp_q.push_back(model[a]);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (data_out !== exp_v) begin
        errors++;
        $display("FAIL read_back addr=%0d got=%b exp=%b", a, data_out, exp_v);
      end
    end
  endtask

  task automatic test_write_blocked();
    @(negedge clk);
    memory_write_enable = 1'b0;
    address_rw = 2'b01;
    data_in = 2'b11;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(model[1]);
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (data_out !== exp_v) begin
        errors++;
        $display("FAIL write_blocked edge=%0d got=%b exp=%b", k, data_out, exp_v);
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      address_rw = N'(a);
      exp_q.push_back(model[a]);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (data_out !== exp_v) begin
        errors++;
        $display("FAIL write_blocked_others addr=%0d got=%b exp=%b", a, data_out, exp_v);
      end
    end
  endtask

  task automatic test_read_during_write();
    @(negedge clk);
    address_rw = 2'b10;
    memory_write_enable = 1'b0;
    data_in = 2'b11;
    #5;
    memory_write_enable = 1'b1;
`ifdef DATA_MEMORY_WRITE_FORWARD_EN
    exp_q.push_back(2'b11);
`else
    exp_q.push_back(model[2]);
`endif
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (data_out !== exp_v) begin
      errors++;
      $display("FAIL rdw_before_edge got=%b exp=%b", data_out, exp_v);
    end
    model[2] = 2'b11;
    exp_q.push_back(model[2]);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (data_out !== exp_v) begin
      errors++;
      $display("FAIL rdw_after_edge got=%b exp=%b", data_out, exp_v);
    end
    @(negedge clk);
    memory_write_enable = 1'b0;
  endtask

  task automatic test_reset_clears();
    @(negedge clk);
    memory_write_enable = 1'b0;
    address_rw = 2'b10;
    #10;
    reset = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      model[a] = '0;
    end
    exp_q.push_back(model[2]);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (data_out !== exp_v) begin
      errors++;
      $display("FAIL reset_immediate got=%b exp=%b", data_out, exp_v);
    end
    #2;
    reset = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      address_rw = N'(a);
      exp_q.push_back(model[a]);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (data_out !== exp_v) begin
        errors++;
        $display("FAIL reset_clears addr=%0d got=%b exp=%b", a, data_out, exp_v);
      end
    end
  endtask

  task automatic test_reset_wins();
    @(negedge clk);
    memory_write_enable = 1'b1;
    address_rw = 2'b01;
    data_in = 2'b10;
    reset = 1'b1;
    exp_q.push_back(model[1]);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (data_out !== exp_v) begin
      errors++;
      $display("FAIL reset_wins_during got=%b exp=%b", data_out, exp_v);
    end
    @(negedge clk);
    memory_write_enable = 1'b0;
    reset = 1'b0;
    exp_q.push_back(model[1]);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (data_out !== exp_v) begin
      errors++;
      $display("FAIL reset_wins_after got=%b exp=%b", data_out, exp_v);
    end
  endtask

  task automatic test_late_change();
    // Enable and address move between edges; only the edge values count.
    @(negedge clk);
    memory_write_enable = 1'b0;
    address_rw = 2'b00;
    data_in = 2'b01;
    #10;
    memory_write_enable = 1'b1;
    address_rw = 2'b11;
    data_in = 2'b10;
    model[3] = 2'b10;
    @(posedge clk);
    #1;
    memory_write_enable = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      address_rw = N'(a);
      exp_q.push_back(model[a]);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (data_out !== exp_v) begin
        errors++;
        $display("FAIL late_change addr=%0d got=%b exp=%b", a, data_out, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_sweep();
    test_read_back();
    test_write_blocked();
    test_read_during_write();
    test_reset_clears();
    test_reset_wins();
    test_late_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
